int_arbiter: RTL and testbench
==============================

// Module: int_arbiter
// PURPOSE
//  Interrupt controller between the peripheral irq lines (segfault, timer, break, sw int)
//  and the CPU interrupt manager. Edge-detects and latches requests, applies a mask,
//  selects one line, holds manager_irq/int_addr until the CPU accepts, and tracks the
//  in-service line until the CPU returns to user mode (priv_lv=1 means user mode).
// PARAMETERS
//  NUM_IRQ     6        number of irq lines, 1..8; line 0 has the highest fixed priority
//  VEC_BASE    16'h10   vector address of line 0
//  VEC_STRIDE  4        vector spacing; int_addr = VEC_BASE + VEC_STRIDE*id, 16-bit wrap
//  MASK_RST    0        reset value of mask[NUM_IRQ-1:0]; bit=1 disables the line
// PORTS
//  clk          in   1        clock; all state changes on posedge
//  rst          in   1        synchronous reset, active-high
//  irq          in   NUM_IRQ  request lines; a rising edge latches a request
//  priv_lv      in   1        1=user mode (interrupts allowed), 0=system mode
//  int_taken    in   1        1-cycle pulse: CPU accepted the vector on int_addr
//  mask_wr      in   1        write strobe for mask
//  mask_data    in   NUM_IRQ  new mask value
//  mask         out  NUM_IRQ  current mask
//  pending      out  NUM_IRQ  latched, not yet accepted requests
//  ack          out  NUM_IRQ  1=line idle; 0=pending or in service (combinational from regs)
//  manager_irq  out  1        interrupt request to the CPU manager
//  int_addr     out  16       vector of the selected line; stable while manager_irq=1
//  cur_id       out  3        id of the selected/in-service line
//  busy         out  1        1 whenever state != IDLE
// BEHAVIOUR
//  Reset: pending=0, irq_q=0, mask=MASK_RST, manager_irq=0, int_addr=0, cur_id=0,
//   state=IDLE, rr_ptr=0, ack=all 1. A line high through reset counts as an edge
//   on the first cycle after reset.
//  Edge detect: irq[i] & ~irq_q[i] sets pending[i] at that edge. pending[i] is cleared
//   only on acceptance; if a new edge and the clear hit the same line in one cycle, set wins.
//  Mask: mask_wr loads mask_data at the edge. Masked lines still latch pending and are
//   never selected; unmasking a pending line makes it eligible next cycle. The mask does
//   not affect a line already in REQ or later.
//  FSM:
//   IDLE : if priv_lv & |(pending & ~mask): pick winner; cur_id<=id, int_addr<=vector,
//          manager_irq<=1, ->REQ. Latency: irq sampled high at edge k -> manager_irq=1
//          after edge k+1.
//   REQ  : if int_taken: pending[cur_id]<=0, manager_irq<=0, ->ENTER.
//          else if !priv_lv (CPU left user mode, e.g. syscall): manager_irq<=0,
//          pending kept, ->IDLE.
//          int_taken wins when both occur.
//   ENTER: wait for priv_lv=0 -> RUN. This absorbs CPU mode-switch latency.
//   RUN  : wait for priv_lv=1 (return to user) -> IDLE. ack[cur_id] returns to 1 here.
//  ack[i] = ~pending[i] & ~(busy & cur_id==i & state!=REQ) & ~(state==REQ & cur_id==i).
//   Net effect: ack[i] is 0 from latch until the return from service.
//  New edges on the in-service line during ENTER/RUN latch a fresh pending request.
//  Only one interrupt is in flight; no nesting. int_taken outside REQ is ignored.
// CONFIGURATION
//  INT_ARB_ROUND_ROBIN_EN defined: the winner is the first eligible line at or after
//   rr_ptr (mod NUM_IRQ). On int_taken, rr_ptr<=(cur_id+1) mod NUM_IRQ.
//  Undefined: fixed priority, lowest index wins; rr_ptr is absent.
// TESTING
//  1 irq[1] 0->1 at cycle 10, priv_lv=1 -> pending=6'b000010 after c10;
//    manager_irq=1, int_addr=16'h14 after c11.
//  2 In REQ, pulse int_taken; priv_lv 1->0 for 5 cycles, then 1 -> pending[1]=0 at once,
//    ack[1]=1 and busy=0 one cycle after priv_lv returns to 1.
//  3 irq[0] and irq[5] rise together -> vector 16'h10 first, then 16'h24 after service;
//    with INT_ARB_ROUND_ROBIN_EN and rr_ptr=1, 16'h24 goes first.
//  4 mask=6'b000100, irq[2] rises -> pending[2]=1, manager_irq stays 0;
//    write mask=0 -> manager_irq=1, int_addr=16'h18 two cycles after mask_wr.
//  5 priv_lv drops in REQ without int_taken -> manager_irq=0, pending kept;
//    re-request on return to user mode.
//  6 rst asserted in RUN with pending=6'b100000 -> after the edge all outputs are at
//    reset values; irq[5] held high -> pending[5]=1 one cycle after reset release.

Source files
------------

// File: rtl/int_arbiter.sv
// Interrupt arbiter: edge-latches irq lines, masks, selects one, and tracks it until the CPU returns to user mode.
// Define INT_ARB_ROUND_ROBIN_EN for round-robin selection; fixed priority (line 0 highest) otherwise.
//
// state | meaning
// IDLE  | no interrupt in flight; selects a winner when in user mode
// REQ   | manager_irq held with int_addr/cur_id until int_taken
// ENTER | vector accepted; waiting for the CPU to enter system mode
// RUN   | handler running; waiting for the return to user mode
module int_arbiter #(
  parameter int                 NUM_IRQ    = 6,
  parameter logic [15:0]        VEC_BASE   = 16'h10,
  parameter int                 VEC_STRIDE = 4,
  parameter logic [NUM_IRQ-1:0] MASK_RST   = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               priv_lv,
  input  logic               int_taken,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_data,
  output logic [NUM_IRQ-1:0] mask,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] ack,
  output logic               manager_irq,
  output logic [15:0]        int_addr,
  output logic [2:0]         cur_id,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, REQ, ENTER, RUN} state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] clr;
  logic [2:0]         win_id;
  logic               win_found;
`ifdef INT_ARB_ROUND_ROBIN_EN
  logic [2:0]         rr_ptr;
`endif

  function automatic logic [15:0] vec_of(input logic [2:0] id);
    return VEC_BASE + 16'(VEC_STRIDE * int'(id));
  endfunction

  assign rise = irq & ~irq_q;
  assign elig = pending & ~mask;
  assign busy = (state != IDLE);

  // Descending scans: the last hit is the lowest index.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
`ifdef INT_ARB_ROUND_ROBIN_EN
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i] && (3'(i) >= rr_ptr)) begin
        win_id    = 3'(i);
        win_found = 1'b1;
      end
    end
    if (!win_found) begin
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
        if (elig[i]) begin
          win_id    = 3'(i);
          win_found = 1'b1;
        end
      end
    end
`else
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_id    = 3'(i);
        win_found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    clr = '0;
    ack = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr[i] = (state == REQ) && int_taken && (cur_id == 3'(i));
      ack[i] = ~pending[i] & ~(busy && (cur_id == 3'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      irq_q       <= '0;
      pending     <= '0;
      mask        <= MASK_RST;
      manager_irq <= 1'b0;
      int_addr    <= '0;
      cur_id      <= '0;
`ifdef INT_ARB_ROUND_ROBIN_EN
      rr_ptr      <= '0;
`endif
    end else begin
      irq_q   <= irq;
      // A fresh edge on the line being accepted survives the clear.
      pending <= (pending & ~clr) | rise;
      if (mask_wr) mask <= mask_data;
      case (state)
        IDLE: begin
          if (priv_lv && win_found) begin
            cur_id      <= win_id;
            int_addr    <= vec_of(win_id);
            manager_irq <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (int_taken) begin
            manager_irq <= 1'b0;
            state       <= ENTER;
`ifdef INT_ARB_ROUND_ROBIN_EN
            if (cur_id == 3'(NUM_IRQ - 1)) rr_ptr <= '0;
            else                           rr_ptr <= cur_id + 3'd1;
`endif
          end else if (!priv_lv) begin
            manager_irq <= 1'b0;
            state       <= IDLE;
          end
        end
        ENTER: begin
          if (!priv_lv) state <= RUN;
        end
        RUN: begin
          if (priv_lv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_arbiter.sv
// Directed bench for int_arbiter with a queue of expected (id, vector) grants.
module tb_int_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  irq;
  logic        priv_lv;
  logic        int_taken;
  logic        mask_wr;
  logic [5:0]  mask_data;
  logic [5:0]  mask;
  logic [5:0]  pending;
  logic [5:0]  ack;
  logic        manager_irq;
  logic [15:0] int_addr;
  logic [2:0]  cur_id;
  logic        busy;

  typedef struct packed {
    logic [2:0]  id;
    logic [15:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  int_arbiter dut (
    .clk(clk), .rst(rst), .irq(irq), .priv_lv(priv_lv), .int_taken(int_taken),
    .mask_wr(mask_wr), .mask_data(mask_data), .mask(mask), .pending(pending),
    .ack(ack), .manager_irq(manager_irq), .int_addr(int_addr), .cur_id(cur_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] id, input logic [15:0] addr);
    exp_t e;
    e.id   = id;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  // Wait for a grant and compare it with the oldest expected one.
  task automatic wait_irq(input string tag);
    exp_t e;
    for (int n = 0; n < 20 && manager_irq !== 1'b1; n++) tick();
    chk({tag, "_seen"}, {15'd0, manager_irq}, 16'd1);
    chk({tag, "_queued"}, (exp_q.size() > 0) ? 16'd1 : 16'd0, 16'd1);
    if (manager_irq === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_addr"}, int_addr, e.addr);
      chk({tag, "_id"}, {13'd0, cur_id}, {13'd0, e.id});
    end
  endtask

  task automatic serve();
    int_taken = 1'b1;
    tick();
    int_taken = 1'b0;
    priv_lv   = 1'b0;
    tick();
    tick();
    priv_lv   = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; irq = '0; priv_lv = 1'b1; int_taken = 1'b0;
    mask_wr = 1'b0; mask_data = '0;
    tick(); tick();
    chk("rst_pending", {10'd0, pending}, 16'h0000);
    chk("rst_mask", {10'd0, mask}, 16'h0000);
    chk("rst_mirq", {15'd0, manager_irq}, 16'd0);
    chk("rst_addr", int_addr, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_ack", {10'd0, ack}, 16'h003f);
    rst = 1'b0;
    repeat (7) tick();

    // 1: latch, then request one edge later
    irq = 6'b000010;
    push_exp(3'd1, 16'h0014);
    tick();
    chk("t1_pending", {10'd0, pending}, 16'h0002);
    chk("t1_mirq_early", {15'd0, manager_irq}, 16'd0);
    chk("t1_ack", {10'd0, ack}, 16'h003d);
    tick();
    chk("t1_mirq", {15'd0, manager_irq}, 16'd1);
    wait_irq("t1");
    chk("t1_busy", {15'd0, busy}, 16'd1);

    // 2: acceptance, mode switch, return
    int_taken = 1'b1;
    tick();
    int_taken = 1'b0;
    priv_lv   = 1'b0;
    chk("t2_pending", {10'd0, pending}, 16'h0000);
    chk("t2_mirq", {15'd0, manager_irq}, 16'd0);
    chk("t2_ack_svc", {10'd0, ack}, 16'h003d);
    repeat (5) tick();
    chk("t2_busy_run", {15'd0, busy}, 16'd1);
    chk("t2_ack_run", {10'd0, ack}, 16'h003d);
    priv_lv = 1'b1;
    tick();
    chk("t2_busy_done", {15'd0, busy}, 16'd0);
    chk("t2_ack_done", {10'd0, ack}, 16'h003f);
    int_taken = 1'b1;
    tick();
    int_taken = 1'b0;
    chk("t2_taken_idle", {15'd0, busy}, 16'd0);

    // 3: simultaneous lines 0 and 5
`ifdef INT_ARB_ROUND_ROBIN_EN
    push_exp(3'd5, 16'h0024);
    push_exp(3'd0, 16'h0010);
`else
    push_exp(3'd0, 16'h0010);
    push_exp(3'd5, 16'h0024);
`endif
    irq = 6'b100001;
    tick();
    chk("t3_pending", {10'd0, pending}, 16'h0021);
    wait_irq("t3_first");
    serve();
    wait_irq("t3_second");
    serve();
    irq = '0;
    tick();
    chk("t3_idle", {15'd0, busy}, 16'd0);

    // 4: masked line latches but is not selected until unmasked
    mask_wr = 1'b1; mask_data = 6'b000100;
    tick();
    mask_wr = 1'b0;
    chk("t4_mask", {10'd0, mask}, 16'h0004);
    irq = 6'b000100;
    push_exp(3'd2, 16'h0018);
    tick();
    chk("t4_pending", {10'd0, pending}, 16'h0004);
    chk("t4_ack", {10'd0, ack}, 16'h003b);
    tick(); tick();
    chk("t4_masked_mirq", {15'd0, manager_irq}, 16'd0);
    mask_wr = 1'b1; mask_data = 6'b000000;
    tick();
    mask_wr = 1'b0;
    chk("t4_unmask_mirq", {15'd0, manager_irq}, 16'd0);
    tick();
    chk("t4_mirq", {15'd0, manager_irq}, 16'd1);
    wait_irq("t4");

    // 5: CPU leaves user mode while requesting
    priv_lv = 1'b0;
    tick();
    chk("t5_mirq_drop", {15'd0, manager_irq}, 16'd0);
    chk("t5_pending_kept", {10'd0, pending}, 16'h0004);
    chk("t5_busy", {15'd0, busy}, 16'd0);
    tick();
    chk("t5_mirq_sys", {15'd0, manager_irq}, 16'd0);
    priv_lv = 1'b1;
    push_exp(3'd2, 16'h0018);
    tick();
    wait_irq("t5_rereq");
    serve();
    irq = '0;
    tick();

    // 6: reset during RUN with a fresh pending line held high
    irq = 6'b001000;
    push_exp(3'd3, 16'h001c);
    tick();
    wait_irq("t6_pre");
    int_taken = 1'b1;
    tick();
    int_taken = 1'b0;
    priv_lv   = 1'b0;
    tick();
    irq = 6'b101000;
    mask_wr = 1'b1; mask_data = 6'b010000;
    tick();
    mask_wr = 1'b0;
    chk("t6_pending", {10'd0, pending}, 16'h0020);
    chk("t6_busy_run", {15'd0, busy}, 16'd1);
    irq = 6'b100000;
    rst = 1'b1;
    priv_lv = 1'b1;
    tick();
    exp_q.delete();
    chk("t6_rst_pending", {10'd0, pending}, 16'h0000);
    chk("t6_rst_mask", {10'd0, mask}, 16'h0000);
    chk("t6_rst_addr", int_addr, 16'h0000);
    chk("t6_rst_id", {13'd0, cur_id}, 16'h0000);
    chk("t6_rst_mirq", {15'd0, manager_irq}, 16'd0);
    chk("t6_rst_busy", {15'd0, busy}, 16'd0);
    chk("t6_rst_ack", {10'd0, ack}, 16'h003f);
    rst = 1'b0;
    push_exp(3'd5, 16'h0024);
    tick();
    chk("t6_relatch", {10'd0, pending}, 16'h0020);
    wait_irq("t6_post");
    serve();
    chk("t6_end_busy", {15'd0, busy}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
